lsu_dccm_arb: RTL and testbench
===============================

Name: lsu_dccm_arb

Overview:
Single-port DCCM access arbiter/scheduler inside lsu. It shares the one DCCM read-or-write slot per cycle between three requesters: core load pipeline (dc1 read), store-buffer drain (write), and the DMA slave (read or write). Core loads have fixed top priority. Store-buffer and DMA rotate round-robin, and a DMA starvation counter escalates DMA to top priority. It also returns DMA read data with fixed 1-cycle latency.

Parameters:
DCCM_BITS, 16, DCCM byte-address width
FDATA_WIDTH, 39, DCCM data width including ECC (32 data + 7 ECC)
DMA_STARVE_MAX, 15, cycles a waiting DMA may be denied before forced priority
CNT_W, $clog2(DMA_STARVE_MAX+1), starvation counter width (derived)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ld_req  in  1  core load requests DCCM read this cycle
ld_addr  in  DCCM_BITS  load address
ld_gnt  out  1  load granted
ld_stall  out  1  ld_req & ~ld_gnt; freezes load pipe
st_req  in  1  store buffer requests a drain write
st_addr  in  DCCM_BITS  store address
st_wdata  in  FDATA_WIDTH  store data with ECC
st_gnt  out  1  store drain granted
dma_req  in  1  DMA access request, held until dma_gnt
dma_write  in  1  1 = write, 0 = read
dma_addr  in  DCCM_BITS  DMA address
dma_wdata  in  FDATA_WIDTH  DMA write data with ECC
dma_gnt  out  1  DMA access granted
dma_ready  out  1  DMA would be granted this cycle if requesting
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  FDATA_WIDTH  DMA read data
nonblock_dma_disable  in  1  chicken bit: disables starvation escalation
dccm_rden  out  1  DCCM read enable
dccm_wren  out  1  DCCM write enable
dccm_rd_addr  out  DCCM_BITS  DCCM read address
dccm_wr_addr  out  DCCM_BITS  DCCM write address
dccm_wr_data  out  FDATA_WIDTH  DCCM write data
dccm_rd_data  in  FDATA_WIDTH  DCCM read data, valid 1 cycle after dccm_rden

Behaviour:
- Exactly one grant per cycle at most (one-hot or zero). Grants are combinational from the current requests and state.
- Priority, evaluated each cycle:
  - If starve_force (starve_cnt==DMA_STARVE_MAX & dma_req & ~nonblock_dma_disable), DMA wins.
  - Else if ld_req, load wins.
  - Else st vs dma by rr_q: rr_q=0 favours st, rr_q=1 favours dma. A lone requester always wins.
- rr_q: set to 1 after st_gnt, set to 0 after dma_gnt, holds otherwise. Reset 0.
- starve_cnt:
  - Increments, saturating at DMA_STARVE_MAX, on each cycle with dma_req & ~dma_gnt.
  - Clears to 0 on dma_gnt or ~dma_req.
  - Holds at 0 while nonblock_dma_disable=1. Reset 0.
- DCCM drive:
  - ld_gnt -> dccm_rden=1, rd_addr=ld_addr.
  - st_gnt -> dccm_wren=1, wr_addr/wr_data=st_*.
  - dma_gnt with dma_write -> wren with dma_*.
  - dma_gnt without dma_write -> rden with rd_addr=dma_addr.
  - Unused address/data outputs driven 0.
- dma_rd_pend_q <= dma_gnt & ~dma_write. dma_rvalid = dma_rd_pend_q; dma_rdata = dccm_rd_data when dma_rvalid, else 0. Latency: grant in cycle N, data in cycle N+1.
- dma_ready = starve_force | (~ld_req & ~(st_req & ~rr_q)). It is valid regardless of dma_req.
- While rst=1: all grants, dccm_rden/wren, dma_ready and dma_rvalid are forced 0; rr_q, starve_cnt and dma_rd_pend_q are cleared.
- Reset mid-operation: a DMA read granted in the cycle reset asserts produces no rvalid. Requesters re-request after reset.
- Requests arriving in the same cycle as a grant of another source wait; nothing is queued internally.
- Simultaneous ld/st/dma with starve_cnt<MAX: load granted; st and dma wait; starve_cnt++.

Decomposition:
- Shared package (swerv_types): enum dccm_src_e {SRC_NONE, SRC_LD, SRC_ST, SRC_DMA} used for the one-hot grant encode and debug.
- One natural sub-module: lsu_dccm_starve_ctr. It is a saturating, clearable counter with a "max" flag, reused later for stbuf-vs-load starvation.

Test Plan:
- Reset held 4 cycles with all requests 1 -> all grants, rden and wren are 0. After release, rr_q=0 and starve_cnt=0.
- st_req=1, dma_req=1 (read, addr 0x0040), no ld for 4 cycles -> grants alternate st, dma, st, dma. In the cycle after each DMA grant, dma_rvalid=1 and dma_rdata equals dccm_rd_data (drive 0x55_1234_5678).
- ld_req held 1 and dma_req held 1 -> ld granted cycles 0..14 and starve_cnt reaches 15. Cycle 15: dma_gnt=1, ld_stall=1, then starve_cnt=0.
- Same stimulus as the previous scenario with nonblock_dma_disable=1 -> dma_gnt stays 0 for 40 cycles and starve_cnt stays 0.
- DMA write (addr 0x0100, wdata 0x7F_DEAD_BEEF) alone -> same cycle: dccm_wren=1 with that addr/data, dma_gnt=1, and dma_rvalid stays 0 next cycle.
- DMA read granted, rst asserted the next cycle -> dma_rvalid=0 in that cycle and all following reset cycles.

Source files
------------

// File: rtl/lsu_dccm_arb_pkg.sv
// Shared types for the DCCM port arbiter: grant source encoding and default sizes.
package lsu_dccm_arb_pkg;

  localparam int DCCM_BITS_DEF   = 16;
  localparam int FDATA_WIDTH_DEF = 39;

  // Which requester owns the single DCCM slot this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_ST   = 2'd2,
    SRC_DMA  = 2'd3
  } dccm_src_e;

  // One-hot view {dma, st, ld} of a grant source, handy for debug and checks.
  function automatic logic [2:0] src_onehot(dccm_src_e src);
    logic [2:0] oh;
    oh = 3'b000;
    case (src)
      SRC_LD:  oh = 3'b001;
      SRC_ST:  oh = 3'b010;
      SRC_DMA: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/lsu_dccm_arb_if.sv
// DCCM array port bundle: the arbiter is master, the RAM model is slave.
interface lsu_dccm_arb_if #(
  parameter int DCCM_BITS   = 16,
  parameter int FDATA_WIDTH = 39
);
  logic                   rden;
  logic                   wren;
  logic [DCCM_BITS-1:0]   rd_addr;
  logic [DCCM_BITS-1:0]   wr_addr;
  logic [FDATA_WIDTH-1:0] wr_data;
  logic [FDATA_WIDTH-1:0] rd_data;

  modport master (
    output rden, wren, rd_addr, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rden, wren, rd_addr, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/lsu_dccm_starve_ctr.sv
// Saturating, clearable wait counter with an "at max" flag.
// Clear wins over increment; the count sticks at MAX until cleared.
module lsu_dccm_starve_ctr #(
  parameter int MAX = 15,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == W'(MAX));

  // Count denied cycles, saturate at MAX, clear on service or withdrawal.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/lsu_dccm_arb.sv
// Single-port DCCM slot arbiter: load > (store <-> DMA round-robin),
// with DMA escalated to top priority after a run of denied cycles.
// DMA read data is returned one cycle after its grant.
module lsu_dccm_arb
  import lsu_dccm_arb_pkg::*;
#(
  parameter int DCCM_BITS      = DCCM_BITS_DEF,
  parameter int FDATA_WIDTH    = FDATA_WIDTH_DEF,
  parameter int DMA_STARVE_MAX = 15,
  parameter int CNT_W          = $clog2(DMA_STARVE_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_req,
  input  logic [DCCM_BITS-1:0]   ld_addr,
  output logic                   ld_gnt,
  output logic                   ld_stall,
  input  logic                   st_req,
  input  logic [DCCM_BITS-1:0]   st_addr,
  input  logic [FDATA_WIDTH-1:0] st_wdata,
  output logic                   st_gnt,
  input  logic                   dma_req,
  input  logic                   dma_write,
  input  logic [DCCM_BITS-1:0]   dma_addr,
  input  logic [FDATA_WIDTH-1:0] dma_wdata,
  output logic                   dma_gnt,
  output logic                   dma_ready,
  output logic                   dma_rvalid,
  output logic [FDATA_WIDTH-1:0] dma_rdata,
  input  logic                   nonblock_dma_disable,
  lsu_dccm_arb_if.master         dccm
);

  dccm_src_e  src_sel;
  logic       rr_q;
  logic       dma_rd_pend_q;
  logic       starve_max;
  logic       starve_force;
  logic [CNT_W-1:0] starve_cnt;

  // Escalation only matters for a DMA that is actually waiting.
  assign starve_force = starve_max & dma_req & ~nonblock_dma_disable & ~rst;

  // Pick the owner of this cycle's DCCM slot.
  always_comb begin
    src_sel = SRC_NONE;
    if (!rst) begin
      if (starve_force)                     src_sel = SRC_DMA;
      else if (ld_req)                      src_sel = SRC_LD;
      else if (st_req && (!dma_req || !rr_q)) src_sel = SRC_ST;
      else if (dma_req)                     src_sel = SRC_DMA;
    end
  end

  assign ld_gnt   = (src_sel == SRC_LD);
  assign st_gnt   = (src_sel == SRC_ST);
  assign dma_gnt  = (src_sel == SRC_DMA);
  assign ld_stall = ld_req & ~ld_gnt;

  // What a DMA would see if it asked now, independent of dma_req.
  assign dma_ready = ~rst & (starve_force | (~ld_req & ~(st_req & ~rr_q)));

  // Steer the winner onto the DCCM port; idle fields are held at zero.
  always_comb begin
    dccm.rden    = 1'b0;
    dccm.wren    = 1'b0;
    dccm.rd_addr = '0;
    dccm.wr_addr = '0;
    dccm.wr_data = '0;
    case (src_sel)
      SRC_LD: begin
        dccm.rden    = 1'b1;
        dccm.rd_addr = ld_addr;
      end
      SRC_ST: begin
        dccm.wren    = 1'b1;
        dccm.wr_addr = st_addr;
        dccm.wr_data = st_wdata;
      end
      SRC_DMA: begin
        if (dma_write) begin
          dccm.wren    = 1'b1;
          dccm.wr_addr = dma_addr;
          dccm.wr_data = dma_wdata;
        end else begin
          dccm.rden    = 1'b1;
          dccm.rd_addr = dma_addr;
        end
      end
      default: ;
    endcase
  end

  // Round-robin pointer: the side just served yields to the other.
  always_ff @(posedge clk) begin
    if (rst)          rr_q <= 1'b0;
    else if (st_gnt)  rr_q <= 1'b1;
    else if (dma_gnt) rr_q <= 1'b0;
  end

  // Remember a DMA read in flight so its data is returned next cycle.
  always_ff @(posedge clk) begin
    if (rst) dma_rd_pend_q <= 1'b0;
    else     dma_rd_pend_q <= dma_gnt & ~dma_write;
  end

  assign dma_rvalid = dma_rd_pend_q & ~rst;
  assign dma_rdata  = dma_rvalid ? dccm.rd_data : '0;

  lsu_dccm_starve_ctr #(
    .MAX (DMA_STARVE_MAX),
    .W   (CNT_W)
  ) u_dma_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (dma_req & ~dma_gnt),
    .clr    (dma_gnt | ~dma_req | nonblock_dma_disable),
    .cnt    (starve_cnt),
    .at_max (starve_max)
  );

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed bench for lsu_dccm_arb: reset, rr alternation, starvation escalation,
// chicken bit, DMA write, store write, and reset during a pending DMA read.
module tb_lsu_dccm_arb;
  import lsu_dccm_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 39;
  localparam logic [DW-1:0] RDATA = 39'h55_1234_5678;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_req, st_req, dma_req, dma_write, nonblock_dma_disable;
  logic [AW-1:0] ld_addr, st_addr, dma_addr;
  logic [DW-1:0] st_wdata, dma_wdata;
  logic          ld_gnt, ld_stall, st_gnt, dma_gnt, dma_ready, dma_rvalid;
  logic [DW-1:0] dma_rdata;

  int checks   = 0;
  int failures = 0;

  lsu_dccm_arb_if #(.DCCM_BITS(AW), .FDATA_WIDTH(DW)) dccm_bus ();

  lsu_dccm_arb dut (
    .clk                  (clk),
    .rst                  (rst),
    .ld_req               (ld_req),
    .ld_addr              (ld_addr),
    .ld_gnt               (ld_gnt),
    .ld_stall             (ld_stall),
    .st_req               (st_req),
    .st_addr              (st_addr),
    .st_wdata             (st_wdata),
    .st_gnt               (st_gnt),
    .dma_req              (dma_req),
    .dma_write            (dma_write),
    .dma_addr             (dma_addr),
    .dma_wdata            (dma_wdata),
    .dma_gnt              (dma_gnt),
    .dma_ready            (dma_ready),
    .dma_rvalid           (dma_rvalid),
    .dma_rdata            (dma_rdata),
    .nonblock_dma_disable (nonblock_dma_disable),
    .dccm                 (dccm_bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ld_req = 1'b1; st_req = 1'b1; dma_req = 1'b1; dma_write = 1'b0;
    nonblock_dma_disable = 1'b0;
    ld_addr = 16'h0010; st_addr = 16'h0020; dma_addr = 16'h0040;
    st_wdata = 39'h01_0000_0001; dma_wdata = 39'h02_0000_0002;
    dccm_bus.rd_data = RDATA;

    // Reset held with every requester asking: nothing may be granted.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_outs", 64'({ld_gnt, st_gnt, dma_gnt, dccm_bus.rden, dccm_bus.wren,
                           dma_ready, dma_rvalid}), 64'd0);
    end
    step();
    rst = 1'b0; ld_req = 1'b0; st_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rr", 64'(dut.rr_q), 64'd0);
    chk("post_rst_cnt", 64'(dut.starve_cnt), 64'd0);
    chk("idle_dma_ready", 64'(dma_ready), 64'd1);

    // Store vs DMA read: st, dma, st, dma; data comes back one cycle after DMA grant.
    step();
    st_req = 1'b1; dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_st_gnt", 64'(st_gnt), 64'(i % 2 == 0));
      chk("rr_dma_gnt", 64'(dma_gnt), 64'(i % 2 == 1));
      chk("rr_rvalid", 64'(dma_rvalid), 64'(i == 2));
      chk("rr_rdata", 64'(dma_rdata), (i == 2) ? 64'(RDATA) : 64'd0);
      if (i % 2 == 1) chk("rr_dma_rd_addr", 64'({dccm_bus.rden, dccm_bus.rd_addr}), 64'h1_0040);
      else            chk("rr_st_wr_addr", 64'({dccm_bus.wren, dccm_bus.wr_addr}), 64'h1_0020);
      step();
    end
    st_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("rr_last_rvalid", 64'(dma_rvalid), 64'd1);
    chk("rr_last_rdata", 64'(dma_rdata), 64'(RDATA));
    chk("rr_ptr_after", 64'(dut.rr_q), 64'd0);

    // Load held against DMA: 15 load grants, then DMA forced through.
    step();
    ld_req = 1'b1; ld_addr = 16'h00A0; dma_req = 1'b1; dma_addr = 16'h00C0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("stv_cnt", 64'(dut.starve_cnt), 64'(i));
      chk("stv_ld_gnt", 64'(ld_gnt), 64'(i < 15));
      chk("stv_dma_gnt", 64'(dma_gnt), 64'(i == 15));
      chk("stv_ld_stall", 64'(ld_stall), 64'(i == 15));
      chk("stv_dma_ready", 64'(dma_ready), 64'(i == 15));
      chk("stv_rd_addr", 64'(dccm_bus.rd_addr), (i < 15) ? 64'h00A0 : 64'h00C0);
      step();
    end
    dma_req = 1'b0;
    @(negedge clk);
    chk("stv_cnt_clear", 64'(dut.starve_cnt), 64'd0);
    chk("stv_rvalid", 64'(dma_rvalid), 64'd1);

    // Chicken bit: escalation disabled, load keeps winning.
    step();
    nonblock_dma_disable = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("nb_dma_gnt", 64'(dma_gnt), 64'd0);
      chk("nb_cnt", 64'(dut.starve_cnt), 64'd0);
      step();
    end
    ld_req = 1'b0; dma_req = 1'b0; nonblock_dma_disable = 1'b0;
    @(negedge clk);

    // Lone DMA write goes straight to the write port, no read return.
    step();
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0100; dma_wdata = 39'h7F_DEAD_BEEF;
    @(negedge clk);
    chk("dw_gnt", 64'(dma_gnt), 64'd1);
    chk("dw_wren_rden", 64'({dccm_bus.wren, dccm_bus.rden}), 64'b10);
    chk("dw_wr_addr", 64'(dccm_bus.wr_addr), 64'h0100);
    chk("dw_wr_data", 64'(dccm_bus.wr_data), 64'h7F_DEAD_BEEF);
    step();
    dma_req = 1'b0; dma_write = 1'b0;
    @(negedge clk);
    chk("dw_no_rvalid", 64'(dma_rvalid), 64'd0);

    // Lone store drain.
    step();
    st_req = 1'b1; st_addr = 16'h0200; st_wdata = 39'h12_3456_789A;
    @(negedge clk);
    chk("st_gnt", 64'(st_gnt), 64'd1);
    chk("st_wr", 64'({dccm_bus.wren, dccm_bus.wr_addr}), 64'h1_0200);
    chk("st_wr_data", 64'(dccm_bus.wr_data), 64'h12_3456_789A);
    chk("st_rd_idle", 64'({dccm_bus.rden, dccm_bus.rd_addr}), 64'd0);

    // DMA read granted, then reset lands before the data cycle.
    step();
    st_req = 1'b0; dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0044;
    @(negedge clk);
    chk("rr_dma_rd_gnt", 64'(dma_gnt), 64'd1);
    step();
    rst = 1'b1; dma_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rvalid", 64'(dma_rvalid), 64'd0);
      chk("rst_rdata", 64'(dma_rdata), 64'd0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_rvalid", 64'(dma_rvalid), 64'd0);
    chk("rel_cnt", 64'(dut.starve_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
